// File: rtl/mmio_pkg.sv
// Register offsets and shared types for the memory-mapped I/O controller.
package mmio_pkg;
  localparam logic [7:0] OFF_LED  = 8'h00;
  localparam logic [7:0] OFF_SEG  = 8'h04;
  localparam logic [7:0] OFF_CTRL = 8'h08;
  localparam logic [7:0] OFF_SW   = 8'h0C;
  localparam logic [7:0] OFF_BTN  = 8'h10;
  localparam logic [7:0] OFF_TMR  = 8'h14;
  localparam logic [7:0] OFF_TCMP = 8'h18;
  localparam logic [7:0] OFF_STAT = 8'h1C;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  typedef struct packed {
    logic irq_en;
    logic seg_en;
  } ctrl_t;
endpackage

// File: rtl/mmio_timer.sv
// Step-gated timer with compare-and-wrap; a CPU write to the counter beats the increment.
module mmio_timer #(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               step_i,
  input  logic               tmr_we_i,
  input  logic               tcmp_we_i,
  input  logic               exp_clr_i,
  input  logic [TIMER_W-1:0] wdata_i,
  output logic [TIMER_W-1:0] tmr_o,
  output logic [TIMER_W-1:0] tcmp_o,
  output logic               expired_o
);
  logic [TIMER_W-1:0] tmr_q, tmr_d, tcmp_q, tcmp_d;
  logic               exp_q, exp_d, match;

  always_comb begin
    match  = (tcmp_q != '0) && (tmr_q == tcmp_q);
    tmr_d  = tmr_q;
    tcmp_d = tcmp_q;
    exp_d  = exp_q & ~exp_clr_i;
    if (tmr_we_i) begin
      tmr_d = wdata_i;
    end else if (step_i) begin
      if (match) begin
        tmr_d = '0;
        exp_d = 1'b1;
      end else begin
        tmr_d = tmr_q + TIMER_W'(1);
      end
    end
    if (tcmp_we_i) tcmp_d = wdata_i;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tmr_q  <= '0;
      tcmp_q <= '0;
      exp_q  <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      tcmp_q <= tcmp_d;
      exp_q  <= exp_d;
    end
  end

  assign tmr_o     = tmr_q;
  assign tcmp_o    = tcmp_q;
  assign expired_o = exp_q;
endmodule

// File: rtl/mmio_ctrl.sv
// CPU-facing I/O register block: window decode, valid/ready handshake with a
// single response buffer, LED/7-segment registers, sticky button events and timer.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int unsigned TIMER_W   = 32
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        step,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  input  logic [15:0] switch,
  input  logic [4:0]  button_down,
  output logic [15:0] led,
  output logic [31:0] seg_value,
  output logic        seg_en,
  output logic        irq
);
  state_t       state_q, state_d;
  logic [31:0]  rsp_rdata_q, rsp_rdata_d, rdata;
  logic [15:0]  led_q, led_d;
  logic [31:0]  seg_q, seg_d;
  ctrl_t        ctrl_q, ctrl_d;
  logic [4:0]   evt_q, evt_d, evt_clr;
  logic         bad_q, bad_d, irq_q, irq_d;
  logic         accept, hit, mapped, rd_en, wr_en, expired;
  logic [7:0]   off;
  logic [TIMER_W-1:0] tmr_v, tcmp_v;
  logic [31:0]  tmr_ext, tcmp_ext;

  assign req_ready = (state_q == IDLE) | rsp_ready;
  assign accept    = req_valid & req_ready;
  assign off       = req_addr[7:0] & 8'hFC;
  assign hit       = (req_addr[31:8] == BASE_ADDR[31:8]);
  assign mapped    = hit && (off <= OFF_STAT);
  assign rd_en     = accept & ~req_we & mapped;
  assign wr_en     = accept & req_we & mapped;

  mmio_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk       (clk),
    .aresetn   (aresetn),
    .step_i    (step),
    .tmr_we_i  (wr_en && (off == OFF_TMR)),
    .tcmp_we_i (wr_en && (off == OFF_TCMP)),
    .exp_clr_i (wr_en && (off == OFF_STAT) && req_wdata[0]),
    .wdata_i   (req_wdata[TIMER_W-1:0]),
    .tmr_o     (tmr_v),
    .tcmp_o    (tcmp_v),
    .expired_o (expired)
  );

  always_comb begin
    tmr_ext  = '0;
    tcmp_ext = '0;
    tmr_ext[TIMER_W-1:0]  = tmr_v;
    tcmp_ext[TIMER_W-1:0] = tcmp_v;
  end

  // Reading BTN_EVT clears exactly the bits it returned.
  always_comb begin
    rdata   = '0;
    evt_clr = '0;
    if (rd_en) begin
      case (off)
        OFF_LED:  rdata = {16'b0, led_q};
        OFF_SEG:  rdata = seg_q;
        OFF_CTRL: rdata = {30'b0, ctrl_q};
        OFF_SW:   rdata = {16'b0, switch};
        OFF_BTN:  begin
          rdata   = {27'b0, evt_q};
          evt_clr = evt_q;
        end
        OFF_TMR:  rdata = tmr_ext;
        OFF_TCMP: rdata = tcmp_ext;
        OFF_STAT: rdata = {30'b0, bad_q, expired};
        default:  rdata = '0;
      endcase
    end
  end

  always_comb begin
    led_d  = led_q;
    seg_d  = seg_q;
    ctrl_d = ctrl_q;
    bad_d  = bad_q;
    evt_d  = (evt_q & ~evt_clr) | button_down;
    irq_d  = expired & ctrl_q.irq_en;
    if (wr_en) begin
      case (off)
        OFF_LED:  led_d  = req_wdata[15:0];
        OFF_SEG:  seg_d  = req_wdata;
        OFF_CTRL: ctrl_d = ctrl_t'(req_wdata[1:0]);
        OFF_STAT: if (req_wdata[1]) bad_d = 1'b0;
        default:  ;
      endcase
    end
    if (accept && !mapped) bad_d = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = RESP;
          rsp_rdata_d = rdata;
        end
      end
      RESP: begin
        if (accept) begin
          rsp_rdata_d = rdata;
        end else if (rsp_ready) begin
          state_d     = IDLE;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      rsp_rdata_q <= '0;
      led_q       <= '0;
      seg_q       <= '0;
      ctrl_q      <= '0;
      evt_q       <= '0;
      bad_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      led_q       <= led_d;
      seg_q       <= seg_d;
      ctrl_q      <= ctrl_d;
      evt_q       <= evt_d;
      bad_q       <= bad_d;
      irq_q       <= irq_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign led       = led_q;
  assign seg_value = seg_q;
  assign seg_en    = ctrl_q.seg_en;
  assign irq       = irq_q;
endmodule
